// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding and fixed widths.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int TXN_CNT_W  = 16;

endpackage

// File: rtl/mem_array_32b.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module mem_array_32b #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write the addressed word on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed wait-state count,
// address checking and a count of error-free completions.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ack,
    output logic                 err,
    output logic                 busy,
    output logic [TXN_CNT_W-1:0] txn_count
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_LIM  = 32'(WORD_BYTES * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        accept;

    // request fields captured at accept; stable for the whole transaction
    logic        we_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;

    logic        bad_p0;
    logic        good_ack;
    logic        mem_wen;
    logic [31:0] mem_rdata;
    logic [IDX_W-1:0] idx_p0;

    assign bad_p0 = (addr_p0[1:0] != 2'b00) || (addr_p0 >= ADDR_LIM);
    assign idx_p0 = addr_p0[IDX_W+1:2];

    // Next-state, wait counter and response outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_nxt = WAIT_INIT;
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        ack      = (state == RESP);
        busy     = (state != IDLE);
        err      = ack && bad_p0;
        good_ack = ack && !bad_p0;
        rdata    = (good_ack && !we_p0) ? mem_rdata : 32'd0;
        // a reset on the RESP edge aborts the write
        mem_wen  = good_ack && we_p0 && reset;
    end

    // State register and wait counter (control, synchronously reset)
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---- accept boundary: capture request fields ----
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= we;
            addr_p0  <= addr;
            wdata_p0 <= wdata;
        end
    end

    // Count error-free completions, wrapping naturally at the top
    always_ff @(posedge clk) begin
        if (!reset) begin
            txn_count <= '0;
        end else if (good_ack) begin
            txn_count <= txn_count + 1'b1;
        end
    end

    mem_array_32b #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clk   (clk),
        .wen   (mem_wen),
        .widx  (idx_p0),
        .wdata (wdata_p0),
        .ridx  (idx_p0),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: WAIT_CYCLES=2 instance for table vectors, reset and
// stability cases; WAIT_CYCLES=0 instance for back-to-back and counter wrap.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req2, we2, req0, we0;
    logic [31:0] addr2, wdata2, addr0, wdata0;
    logic [31:0] rdata2, rdata0;
    logic        ack2, err2, busy2, ack0, err0, busy0;
    logic [15:0] txn2, txn0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .rdata(rdata2), .ack(ack2), .err(err2), .busy(busy2), .txn_count(txn2)
    );

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0), .txn_count(txn0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            req2 = r; we2 = w; addr2 = a; wdata2 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    function automatic logic cur_ack(input bit sel);
        return sel ? ack2 : ack0;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic txn(input bit sel, input logic t_we, input logic [31:0] t_addr,
                       input logic [31:0] t_wdata, input bit perturb,
                       output logic [31:0] o_rdata, output logic o_err,
                       output int o_lat, output bit o_ack);
        drive(sel, 1'b1, t_we, t_addr, t_wdata);
        @(posedge clk);
        o_ack = 1'b0; o_lat = 0; o_rdata = '0; o_err = 1'b0;
        for (int k = 1; k <= 20 && !o_ack; k++) begin
            @(negedge clk);
            if (perturb && k == 1) drive(sel, 1'b1, t_we, t_addr ^ 32'h4, ~t_wdata);
            if (cur_ack(sel)) begin
                o_ack   = 1'b1;
                o_lat   = k;
                o_rdata = sel ? rdata2 : rdata0;
                o_err   = sel ? err2 : err0;
            end
        end
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ak;
        int          exp_cnt;
        int          acks;
        int          idx;
        bit          exp_ack;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0013, 32'h5555_5555, 32'h0,         1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'h7777_7777, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_00FF, 32'h0,         32'h0,         1'b1};
        vecs[12] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0,         1'b0};
        vecs[13] = '{1'b1, 32'h0000_0024, 32'h2424_2424, 32'h0,         1'b0};
        vecs[14] = '{1'b1, 32'h0000_0034, 32'h3434_3434, 32'h0,         1'b0};
        vecs[15] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1111_1111, 1'b0};

        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack",  {31'd0, ack2},  32'd0);
        check("reset_err",  {31'd0, err2},  32'd0);
        check("reset_rdata", rdata2,        32'd0);
        check("reset_busy", {31'd0, busy2}, 32'd0);
        check("reset_txn",  {16'd0, txn2},  32'd0);
        check("reset_txn0", {16'd0, txn0},  32'd0);
        reset = 1'b1;
        @(negedge clk);

        // table vectors on the two-wait-state instance
        exp_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, lat, ak);
            if (!vecs[i].exp_err) exp_cnt++;
            check($sformatf("vec%0d_ack", i),   {31'd0, ak}, 32'd1);
            check($sformatf("vec%0d_lat", i),   lat,         32'd3);
            check($sformatf("vec%0d_err", i),   {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_rdata", i), rd,          vecs[i].exp_rdata);
            check($sformatf("vec%0d_txn", i),   {16'd0, txn2}, 32'(exp_cnt));
        end

        // input changes after accept must not disturb the write
        txn(1'b1, 1'b1, 32'h30, 32'h0BAD_CAFE, 1'b1, rd, er, lat, ak);
        check("stable_ack", {31'd0, ak}, 32'd1);
        txn(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat, ak);
        check("stable_rd30", rd, 32'h0BAD_CAFE);
        txn(1'b1, 1'b0, 32'h34, 32'h0, 1'b0, rd, er, lat, ak);
        check("stable_rd34", rd, 32'h3434_3434);

        // reset during WAIT aborts the write
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        check("wait_busy", {31'd0, busy2}, 32'd1);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            if (ack2) acks++;
            @(negedge clk);
        end
        check("abort_wait_noack", acks, 32'd0);
        check("abort_wait_txn", {16'd0, txn2}, 32'd0);
        check("abort_wait_busy", {31'd0, busy2}, 32'd0);

        // reset during RESP aborts the write
        drive(1'b1, 1'b1, 1'b1, 32'h24, 32'hFFFF_0000);
        @(posedge clk);
        ak = 1'b0;
        for (int k = 0; k < 20 && !ak; k++) begin
            @(negedge clk);
            ak = ack2;
        end
        check("abort_resp_seen", {31'd0, ak}, 32'd1);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        // request present on the first edge after reset release
        txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, ak);
        check("post_reset_lat", lat, 32'd3);
        check("post_reset_rd20", rd, 32'h1111_1111);
        txn(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, rd, er, lat, ak);
        check("post_reset_rd24", rd, 32'h2424_2424);
        check("post_reset_txn", {16'd0, txn2}, 32'd2);

        // zero-wait instance: preload, then back-to-back reads with req held
        for (int i = 0; i < 3; i++) begin
            txn(1'b0, 1'b1, 32'(4 * i), 32'(32'hA0 + i), 1'b0, rd, er, lat, ak);
            check($sformatf("w0_lat%0d", i), lat, 32'd1);
        end
        idx = 0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_ack = (k % 2 == 0) && (k < 6);
            check($sformatf("b2b_ack%0d", k),  {31'd0, ack0},  {31'd0, exp_ack});
            check($sformatf("b2b_busy%0d", k), {31'd0, busy0}, {31'd0, exp_ack});
            if (ack0) begin
                check($sformatf("b2b_rdata%0d", idx), rdata0, 32'(32'hA0 + idx));
                idx++;
                if (idx < 3) drive(1'b0, 1'b1, 1'b0, 32'(4 * idx), 32'h0);
                else         drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        check("b2b_txn", {16'd0, txn0}, 32'd6);

        // counter wrap
        force dut0.txn_count = 16'hFFFF;
        #1;
        release dut0.txn_count;
        @(negedge clk);
        txn(1'b0, 1'b0, 32'h2, 32'h0, 1'b0, rd, er, lat, ak);
        check("wrap_err_flag", {31'd0, er}, 32'd1);
        check("wrap_err_hold", {16'd0, txn0}, 32'h0000_FFFF);
        txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, ak);
        check("wrap_rdata", rd, 32'hA0);
        check("wrap_zero", {16'd0, txn0}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
